// File: rtl/gearbox_param.sv
// Width-converting gearbox: IN_W words in, OUT_W words out, through a
// circular buffer of UNIT_W-bit units with fill tracking and flush drain.
module gearbox_param #(
    parameter int IN_W        = 16,
    parameter int OUT_W       = 20,
    parameter int UNIT_W      = 4,
    parameter int DEPTH_UNITS = 32
) (
    input  logic                           clk,
    input  logic                           res_n,
    input  logic                           shift_in,
    input  logic [IN_W-1:0]                data_in,
    output logic                           full,
    output logic                           drop_err,
    input  logic                           shift_out,
    input  logic                           flush,
    output logic                           valid_out,
    output logic [OUT_W-1:0]               data_out,
    output logic                           last_out,
    output logic [$clog2(DEPTH_UNITS):0]   fill_level
);

    localparam int IN_U  = IN_W / UNIT_W;
    localparam int OUT_U = OUT_W / UNIT_W;
    localparam int AW    = $clog2(DEPTH_UNITS);
    localparam int FW    = AW + 1;

    logic [UNIT_W-1:0] mem [DEPTH_UNITS];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [FW-1:0]     consumed;
    logic [OUT_W-1:0]  rd_word;
    logic              wr_en;
    logic              nrm_rd;
    logic              fl_rd;
    logic              rd_en;
    logic              rd_last;

    assign full    = (FW'(DEPTH_UNITS) - fill_level) < FW'(IN_U);
    assign wr_en   = shift_in && !full;
    assign nrm_rd  = shift_out && (fill_level >= FW'(OUT_U));
    assign fl_rd   = shift_out && flush && (fill_level != '0)
                     && (fill_level < FW'(OUT_U));
    assign rd_en   = nrm_rd || fl_rd;
    assign consumed = nrm_rd ? FW'(OUT_U) : (fl_rd ? fill_level : '0);
    assign rd_last = flush && rd_en && (consumed == fill_level);

    // Short flush reads zero-pad the units beyond the current fill.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < OUT_U; k++) begin
            if (nrm_rd || (FW'(k) < fill_level)) begin
                rd_word[k*UNIT_W +: UNIT_W] = mem[rd_ptr + AW'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < IN_U; k++) begin
                mem[wr_ptr + AW'(k)] <= data_in[k*UNIT_W +: UNIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            valid_out  <= 1'b0;
            last_out   <= 1'b0;
            data_out   <= '0;
            drop_err   <= 1'b0;
        end else begin
            drop_err  <= shift_in && full;
            valid_out <= rd_en;
            last_out  <= rd_last;
            if (rd_en) begin
                data_out <= rd_word;
                rd_ptr   <= rd_ptr + AW'(consumed);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(IN_U);
            end
            fill_level <= fill_level + (wr_en ? FW'(IN_U) : FW'(0))
                          - consumed;
        end
    end

endmodule
